basemul_accumulator: RTL and testbench

Downstream stage of the NTT-domain base-case multiplier. Consumes the stream of reduced (c0, c1) coefficient pairs the multiplier produces for one polynomial product, sums K such products pointwise modulo q = 3329 (the matrix-vector inner product of ML-KEM, e.g. Â∘ŝ summed over k), and streams out the canonical result pairs. It holds one full polynomial (128 pairs) of partial sums in an internal register buffer.

---
 rtl/basemul_accumulator_if.sv | 22 ++
 rtl/basemul_accumulator.sv | 145 ++++++++++++++
 tb/tb_basemul_accumulator.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/basemul_accumulator_if.sv
// rtl/basemul_accumulator_if.sv - coefficient-pair input and result-pair output streams of the accumulator
interface basemul_accumulator_if;
    logic               in_valid_i;
    logic               in_ready_o;
    logic signed [15:0] c0_i;
    logic signed [15:0] c1_i;
    logic               out_valid_o;
    logic               out_ready_i;
    logic [15:0]        out_c0_o;
    logic [15:0]        out_c1_o;
    logic               out_last_o;

    modport master (
        output in_valid_i, c0_i, c1_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_c0_o, out_c1_o, out_last_o
    );

    modport slave (
        input  in_valid_i, c0_i, c1_i, out_ready_i,
        output in_ready_o, out_valid_o, out_c0_o, out_c1_o, out_last_o
    );
endinterface

// File: rtl/basemul_accumulator.sv
// rtl/basemul_accumulator.sv - sums K base-mul products pointwise mod 3329; input range checker under BASEMUL_ACC_RANGE_CHECK_EN
module basemul_accumulator #(
    parameter int N_PAIRS = 128,
    parameter int K_MAX   = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [2:0]           k_i,
    basemul_accumulator_if.slave bus,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o
);

    localparam int               IDX_W    = $clog2(N_PAIRS);
    localparam logic [15:0]      Q        = 16'd3329;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PAIRS - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, FLUSH} state_t;

    state_t           state_q, state_d;
    logic [2:0]       k_q;
    logic [2:0]       poly_idx;
    logic [IDX_W-1:0] pair_idx;
    logic             out_valid_q, out_last_q, done_q;
    logic [15:0]      out_c0_q, out_c1_q;
    logic             in_ready, accept, start_ok, final_pass, last_pair;
    logic [15:0]      res_c0, res_c1;

    // Partial sums are canonical (0..q-1), so 12 bits per coefficient suffice.
    logic [11:0] acc_c0 [N_PAIRS];
    logic [11:0] acc_c1 [N_PAIRS];

    function automatic logic [15:0] norm(input logic [15:0] x);
        return x[15] ? x + Q : x;
    endfunction

    function automatic logic [15:0] mod_add(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] s;
        s = a + b;
        return (s >= Q) ? s - Q : s;
    endfunction

    assign start_ok   = start_i && (k_i != 3'd0) && (k_i <= 3'(K_MAX));
    assign final_pass = (poly_idx == k_q - 3'd1);
    assign last_pair  = (pair_idx == LAST_IDX);
    assign accept     = bus.in_valid_i && in_ready;

    always_comb begin
        res_c0 = norm(bus.c0_i);
        res_c1 = norm(bus.c1_i);
        if (poly_idx != 3'd0) begin
            res_c0 = mod_add({4'b0, acc_c0[pair_idx]}, norm(bus.c0_i));
            res_c1 = mod_add({4'b0, acc_c1[pair_idx]}, norm(bus.c1_i));
        end
    end

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        busy_o   = (state_q != IDLE);
        case (state_q)
            IDLE: if (start_ok) state_d = ACCUM;
            ACCUM: begin
                // Final pass is a 1-deep output pipeline, so only stall on a held result.
                in_ready = !final_pass || !out_valid_q || bus.out_ready_i;
                if (bus.in_valid_i && in_ready && final_pass && last_pair) state_d = FLUSH;
            end
            FLUSH: if (out_valid_q && bus.out_ready_i && out_last_q) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            k_q         <= 3'd0;
            pair_idx    <= '0;
            poly_idx    <= 3'd0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_c0_q    <= 16'd0;
            out_c1_q    <= 16'd0;
            done_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == FLUSH) && (state_d == IDLE);
            if (state_q == IDLE && start_ok) begin
                k_q      <= k_i;
                pair_idx <= '0;
                poly_idx <= 3'd0;
            end else if (accept) begin
                pair_idx <= pair_idx + 1'b1;
                if (last_pair) poly_idx <= poly_idx + 3'd1;
            end
            if (accept && final_pass) begin
                out_valid_q <= 1'b1;
                out_c0_q    <= res_c0;
                out_c1_q    <= res_c1;
                out_last_q  <= last_pair;
            end else if (bus.out_ready_i) begin
                out_valid_q <= 1'b0;
                out_last_q  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept && !final_pass) begin
            acc_c0[pair_idx] <= res_c0[11:0];
            acc_c1[pair_idx] <= res_c1[11:0];
        end
    end

`ifdef BASEMUL_ACC_RANGE_CHECK_EN
    logic err_q;
    logic bad_in;

    assign bad_in = ($signed(bus.c0_i) > 16'sd3328) || ($signed(bus.c0_i) < -16'sd3328) ||
                    ($signed(bus.c1_i) > 16'sd3328) || ($signed(bus.c1_i) < -16'sd3328);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else if (state_q == IDLE && start_ok) begin
            err_q <= 1'b0;
        end else if (accept && bad_in) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

    assign done_o          = done_q;
    assign bus.in_ready_o  = in_ready;
    assign bus.out_valid_o = out_valid_q;
    assign bus.out_c0_o    = out_c0_q;
    assign bus.out_c1_o    = out_c1_q;
    assign bus.out_last_o  = out_last_q;

endmodule

// File: tb/tb_basemul_accumulator.sv
// tb/tb_basemul_accumulator.sv - randomized self-checking bench for basemul_accumulator against a modular-sum reference
module tb_basemul_accumulator;
    localparam int N = 128;
    localparam int Q = 3329;
`ifdef BASEMUL_ACC_RANGE_CHECK_EN
    localparam int ERR_EXP = 1;
`else
    localparam int ERR_EXP = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [2:0] k_in = 3'd0;
    logic       busy, done, err;

    basemul_accumulator_if bus();

    basemul_accumulator #(.N_PAIRS(N), .K_MAX(4)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .start_i(start),
        .k_i    (k_in),
        .bus    (bus),
        .busy_o (busy),
        .done_o (done),
        .err_o  (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int stim0 [4*N];
    int stim1 [4*N];
    int q0 [$];
    int q1 [$];
    int ql [$];
    int accepted, first_out_at, done_cycle, last_hs_cycle;
    int hold_viol, ready_viol, stalled_seen, timeout;
    int err_at_done, err_first, busy_at_done, bad_idx;

    // Reference: the plain integer sum of all k inputs at an index, reduced into 0..q-1.
    function automatic int ref_val(input int ch, input int idx, input int k);
        int s = 0;
        for (int p = 0; p < k; p++) s += (ch == 0) ? stim0[p*N+idx] : stim1[p*N+idx];
        s = s % Q;
        if (s < 0) s += Q;
        return s;
    endfunction

    function automatic int rnd_coeff();
        return int'($urandom_range(2*Q-2)) - (Q-1);
    endfunction

    function automatic int data_errs(input int k);
        int e = 0;
        bad_idx = -1;
        for (int i = 0; i < q0.size() && i < N; i++) begin
            if (q0[i] != ref_val(0, i, k) || q1[i] != ref_val(1, i, k) || ql[i] != ((i == N-1) ? 1 : 0)) begin
                e++;
                if (bad_idx < 0) bad_idx = i;
            end
        end
        return e + ((q0.size() > N) ? q0.size() - N : N - q0.size());
    endfunction

    task automatic fill_random(input int k);
        for (int i = 0; i < k*N; i++) begin
            stim0[i] = rnd_coeff();
            stim1[i] = rnd_coeff();
        end
    endtask

    task automatic fill_pass(input int p, input int a, input int b);
        for (int i = 0; i < N; i++) begin
            stim0[p*N+i] = a;
            stim1[p*N+i] = b;
        end
    endtask

    task automatic run_job(input int k, input int vpct, input int rpct, input int stall_at,
                           input int glitch_at, input int abort_after);
        int i = 0, cyc = 0, total = k*N, stall_left = 0;
        bit stalled_done = 0, prev_hold = 0, stalling;
        logic [15:0] p0 = 16'd0, p1 = 16'd0;
        logic pl = 1'b0;
        q0.delete(); q1.delete(); ql.delete();
        first_out_at = -1; done_cycle = -1; last_hs_cycle = -1;
        hold_viol = 0; ready_viol = 0; stalled_seen = 0; timeout = 0;
        err_at_done = -1; err_first = -1; busy_at_done = -1;
        @(negedge clk);
        start = 1'b1; k_in = 3'(k); bus.in_valid_i = 1'b0; bus.out_ready_i = 1'b1;
        forever begin
            @(negedge clk);
            cyc++;
            start = (glitch_at >= 0 && i == glitch_at);
            if (start) k_in = 3'd1;
            if (abort_after >= 0 && i >= abort_after) break;
            bus.in_valid_i = (i < total) && ($urandom_range(99) < vpct);
            bus.c0_i = (i < total) ? 16'(stim0[i]) : 16'd0;
            bus.c1_i = (i < total) ? 16'(stim1[i]) : 16'd0;
            if (stall_at >= 0 && !stalled_done && q0.size() == stall_at) begin
                stall_left = 5;
                stalled_done = 1;
            end
            stalling = (stall_left > 0);
            if (stalling) begin
                bus.out_ready_i = 1'b0;
                stall_left--;
            end else begin
                bus.out_ready_i = ($urandom_range(99) < rpct);
            end
            #1;
            if (cyc == 1) err_first = err;
            if (stalling && bus.out_valid_o) stalled_seen++;
            if (prev_hold && (bus.out_valid_o !== 1'b1 || bus.out_c0_o !== p0 ||
                              bus.out_c1_o !== p1 || bus.out_last_o !== pl)) hold_viol++;
            if (done) begin
                done_cycle = cyc; err_at_done = err; busy_at_done = busy;
                break;
            end
            if (i < (k-1)*N && !bus.in_ready_o) ready_viol++;
            if (i >= (k-1)*N && bus.out_valid_o && !bus.out_ready_i && bus.in_ready_o) ready_viol++;
            if (i >= (k-1)*N && i < total && !(bus.out_valid_o && !bus.out_ready_i) && !bus.in_ready_o) ready_viol++;
            prev_hold = bus.out_valid_o && !bus.out_ready_i;
            p0 = bus.out_c0_o; p1 = bus.out_c1_o; pl = bus.out_last_o;
            if (bus.out_valid_o && first_out_at < 0) first_out_at = i;
            if (bus.out_valid_o && bus.out_ready_i) begin
                q0.push_back(int'(bus.out_c0_o));
                q1.push_back(int'(bus.out_c1_o));
                ql.push_back(int'(bus.out_last_o));
                if (bus.out_last_o) last_hs_cycle = cyc;
            end
            if (bus.in_valid_i && bus.in_ready_o) i++;
            if (cyc > 6000) begin
                timeout = 1;
                break;
            end
        end
        start = 1'b0; bus.in_valid_i = 1'b0; bus.out_ready_i = 1'b1;
        accepted = i;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %0b want 0", busy); end
        checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got %0b want 0", done); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got %0b want 0", err); end
        checks++; if (bus.in_ready_o !== 1'b0) begin failures++; $display("FAIL reset_in_ready got %0b want 0", bus.in_ready_o); end
        checks++; if (bus.out_valid_o !== 1'b0) begin failures++; $display("FAIL reset_out_valid got %0b want 0", bus.out_valid_o); end
        checks++; if (bus.out_last_o !== 1'b0) begin failures++; $display("FAIL reset_out_last got %0b want 0", bus.out_last_o); end
        checks++; if ({bus.out_c0_o, bus.out_c1_o} !== 32'd0) begin failures++; $display("FAIL reset_out_data got %0d,%0d want 0,0", bus.out_c0_o, bus.out_c1_o); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_k1_directed();
        fill_pass(0, -1, 5);
        run_job(1, 100, 100, -1, -1, -1);
        checks++; if (timeout != 0) begin failures++; $display("FAIL k1_timeout got %0d want 0", timeout); end
        checks++; if (data_errs(1) != 0) begin failures++; $display("FAIL k1_data errors=%0d first_idx=%0d want 0 errors", data_errs(1), bad_idx); end
        checks++; if (q0.size() == N && (q0[0] != 3328 || q1[N-1] != 5)) begin failures++; $display("FAIL k1_value got %0d,%0d want 3328,5", q0[0], q1[N-1]); end
        checks++; if (done_cycle != last_hs_cycle + 1) begin failures++; $display("FAIL k1_done_timing got %0d want %0d", done_cycle, last_hs_cycle + 1); end
        checks++; if (done_cycle != N + 2) begin failures++; $display("FAIL k1_latency got %0d want %0d", done_cycle, N + 2); end
        checks++; if (busy_at_done != 0) begin failures++; $display("FAIL k1_busy_at_done got %0d want 0", busy_at_done); end
        checks++; if (ready_viol != 0) begin failures++; $display("FAIL k1_ready_rule got %0d want 0", ready_viol); end
    endtask

    task automatic test_k2_directed();
        fill_pass(0, 3328, 0);
        fill_pass(1, 3328, -3328);
        run_job(2, 100, 100, -1, -1, -1);
        checks++; if (data_errs(2) != 0 || timeout != 0) begin failures++; $display("FAIL k2_data errors=%0d timeout=%0d want 0", data_errs(2), timeout); end
        checks++; if (q0.size() == N && (q0[5] != 3327 || q1[5] != 1)) begin failures++; $display("FAIL k2_value got %0d,%0d want 3327,1", q0[5], q1[5]); end
    endtask

    task automatic test_k4_directed();
        for (int p = 0; p < 4; p++) fill_pass(p, 1000, -1000);
        run_job(4, 100, 100, -1, -1, -1);
        checks++; if (data_errs(4) != 0 || timeout != 0) begin failures++; $display("FAIL k4_data errors=%0d timeout=%0d want 0", data_errs(4), timeout); end
        checks++; if (q0.size() == N && (q0[N-1] != 671 || q1[0] != 2658)) begin failures++; $display("FAIL k4_value got %0d,%0d want 671,2658", q0[N-1], q1[0]); end
        checks++; if (first_out_at != 3*N + 1) begin failures++; $display("FAIL k4_first_output got %0d want %0d", first_out_at, 3*N + 1); end
    endtask

    task automatic test_backpressure();
        fill_random(2);
        run_job(2, 100, 100, 40, -1, -1);
        checks++; if (data_errs(2) != 0 || timeout != 0) begin failures++; $display("FAIL bp_data errors=%0d timeout=%0d want 0", data_errs(2), timeout); end
        checks++; if (stalled_seen != 5) begin failures++; $display("FAIL bp_stall_cycles got %0d want 5", stalled_seen); end
        checks++; if (hold_viol != 0) begin failures++; $display("FAIL bp_hold got %0d want 0", hold_viol); end
        checks++; if (ready_viol != 0) begin failures++; $display("FAIL bp_ready_rule got %0d want 0", ready_viol); end
    endtask

    task automatic test_random_jobs();
        for (int j = 0; j < 4; j++) begin
            int k = j + 1;
            fill_random(k);
            run_job(k, 70, 60, -1, (j == 2) ? 50 : -1, -1);
            checks++; if (data_errs(k) != 0 || timeout != 0) begin failures++; $display("FAIL rand_data k=%0d errors=%0d first_idx=%0d timeout=%0d want 0", k, data_errs(k), bad_idx, timeout); end
            checks++; if (hold_viol != 0 || ready_viol != 0) begin failures++; $display("FAIL rand_handshake k=%0d hold=%0d ready=%0d want 0", k, hold_viol, ready_viol); end
            checks++; if (accepted != k*N) begin failures++; $display("FAIL rand_accepts k=%0d got %0d want %0d", k, accepted, k*N); end
        end
    endtask

    task automatic test_bad_start();
        int bad_k [4] = '{0, 5, 6, 7};
        for (int j = 0; j < 4; j++) begin
            @(negedge clk);
            start = 1'b1; k_in = 3'(bad_k[j]);
            @(negedge clk);
            start = 1'b0;
            #1;
            checks++; if (busy !== 1'b0 || bus.in_ready_o !== 1'b0) begin failures++; $display("FAIL bad_start k=%0d busy=%0b in_ready=%0b want 0,0", bad_k[j], busy, bus.in_ready_o); end
        end
    endtask

    task automatic test_reset_mid_job();
        int spurious = 0;
        fill_random(3);
        run_job(3, 100, 100, -1, -1, 60);
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if ({busy, done, err, bus.in_ready_o, bus.out_valid_o, bus.out_last_o} !== 6'd0) begin failures++; $display("FAIL midreset_flags got %b want 000000", {busy, done, err, bus.in_ready_o, bus.out_valid_o, bus.out_last_o}); end
        checks++; if ({bus.out_c0_o, bus.out_c1_o} !== 32'd0) begin failures++; $display("FAIL midreset_data got %0d,%0d want 0,0", bus.out_c0_o, bus.out_c1_o); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            #1;
            if (done || busy) spurious++;
        end
        checks++; if (spurious != 0) begin failures++; $display("FAIL midreset_no_done got %0d want 0", spurious); end
        fill_random(1);
        run_job(1, 100, 100, -1, -1, -1);
        checks++; if (data_errs(1) != 0 || timeout != 0) begin failures++; $display("FAIL midreset_fresh_job errors=%0d timeout=%0d want 0", data_errs(1), timeout); end
    endtask

    task automatic test_range_check();
        fill_random(1);
        stim0[10] = 3329;
        run_job(1, 100, 100, -1, -1, -1);
        checks++; if (err_at_done != ERR_EXP) begin failures++; $display("FAIL range_err_at_done got %0d want %0d", err_at_done, ERR_EXP); end
        checks++; if (q0.size() != N || timeout != 0) begin failures++; $display("FAIL range_count got %0d want %0d", q0.size(), N); end
        fill_random(1);
        run_job(1, 100, 100, -1, -1, -1);
        checks++; if (err_first != 0) begin failures++; $display("FAIL range_err_cleared got %0d want 0", err_first); end
        checks++; if (err_at_done != 0 || data_errs(1) != 0) begin failures++; $display("FAIL range_clean_job err=%0d errors=%0d want 0,0", err_at_done, data_errs(1)); end
    endtask

    initial begin
        bus.in_valid_i = 1'b0;
        bus.c0_i = 16'd0;
        bus.c1_i = 16'd0;
        bus.out_ready_i = 1'b1;
        test_reset();
        test_k1_directed();
        test_k2_directed();
        test_k4_directed();
        test_backpressure();
        test_random_jobs();
        test_bad_start();
        test_reset_mid_job();
        test_range_check();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
